// File: rtl/pipeline_execute_if.sv
// pipeline_execute_if: ID/EX-to-EX/MEM bus bundle; slave is the register, master drives it
interface pipeline_execute_if #(
  parameter int WORD_W = 32,
  parameter int REG_AW = 5
);
  logic              hit_check, hit_check2, stall, flush;
  logic [WORD_W-1:0] ex_instr_in, ex_npc_in, ex_alu_result_in, ex_rdat2_in;
  logic              ex_zero_in, ex_overflow_in;
  logic [REG_AW-1:0] ex_wsel_in;
  logic              ex_regwen_in, ex_mem2reg_in, ex_memwrite_in, ex_pc2reg_in, ex_careof_in, ex_halt_in;
  logic [WORD_W-1:0] mem_instr_out, mem_npc_out, mem_alu_result_out, mem_rdat2_out;
  logic              mem_zero_out, mem_regwen_out, mem_mem2reg_out, mem_memwrite_out, mem_pc2reg_out, mem_halt_out;
  logic [REG_AW-1:0] mem_wsel_out;
  logic              ov_trap_out, halted_out;
  logic [31:0]       bubble_cnt_out, instr_cnt_out;
  modport slave (
    input  hit_check, hit_check2, stall, flush,
           ex_instr_in, ex_npc_in, ex_alu_result_in, ex_rdat2_in, ex_zero_in, ex_overflow_in, ex_wsel_in,
           ex_regwen_in, ex_mem2reg_in, ex_memwrite_in, ex_pc2reg_in, ex_careof_in, ex_halt_in,
    output mem_instr_out, mem_npc_out, mem_alu_result_out, mem_rdat2_out, mem_zero_out, mem_regwen_out,
           mem_mem2reg_out, mem_memwrite_out, mem_pc2reg_out, mem_halt_out, mem_wsel_out,
           ov_trap_out, halted_out, bubble_cnt_out, instr_cnt_out
  );
  modport master (
    output hit_check, hit_check2, stall, flush,
           ex_instr_in, ex_npc_in, ex_alu_result_in, ex_rdat2_in, ex_zero_in, ex_overflow_in, ex_wsel_in,
           ex_regwen_in, ex_mem2reg_in, ex_memwrite_in, ex_pc2reg_in, ex_careof_in, ex_halt_in,
    input  mem_instr_out, mem_npc_out, mem_alu_result_out, mem_rdat2_out, mem_zero_out, mem_regwen_out,
           mem_mem2reg_out, mem_memwrite_out, mem_pc2reg_out, mem_halt_out, mem_wsel_out,
           ov_trap_out, halted_out, bubble_cnt_out, instr_cnt_out
  );
endinterface

// File: rtl/pipeline_execute.sv
// pipeline_execute: EX/MEM register with overflow squash, bubbles and halt freeze; EXMEM_PERF_EN adds bubble/instr counters
module pipeline_execute (
  input logic CLK,
  input logic nRST,
  pipeline_execute_if.slave exif
);
  typedef enum logic {RUN, HALTED} state_t;
  state_t state, next_state;
  logic update, bubble, load, squash;
  assign update = exif.hit_check & ~exif.hit_check2;
  assign bubble = exif.stall | exif.flush;
  assign load = (state == RUN) & update;
  assign squash = exif.ex_careof_in & exif.ex_overflow_in;
  assign exif.halted_out = (state == HALTED);
  // state register
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) state <= RUN;
    else state <= next_state;
  // halt freezes once a real halt instruction is latched
  always_comb begin
    next_state = state;
    if (load && !bubble && exif.ex_halt_in) next_state = HALTED;
  end
  // pipeline register: bubble zeroes everything except the sticky trap
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      exif.mem_instr_out      <= '0;
      exif.mem_npc_out        <= '0;
      exif.mem_alu_result_out <= '0;
      exif.mem_rdat2_out      <= '0;
      exif.mem_wsel_out       <= '0;
      exif.mem_zero_out       <= 1'b0;
      exif.mem_regwen_out     <= 1'b0;
      exif.mem_mem2reg_out    <= 1'b0;
      exif.mem_memwrite_out   <= 1'b0;
      exif.mem_pc2reg_out     <= 1'b0;
      exif.mem_halt_out       <= 1'b0;
      exif.ov_trap_out        <= 1'b0;
    end else if (load) begin
      exif.mem_instr_out      <= bubble ? '0 : exif.ex_instr_in;
      exif.mem_npc_out        <= bubble ? '0 : exif.ex_npc_in;
      exif.mem_alu_result_out <= bubble ? '0 : exif.ex_alu_result_in;
      exif.mem_rdat2_out      <= bubble ? '0 : exif.ex_rdat2_in;
      exif.mem_wsel_out       <= bubble ? '0 : exif.ex_wsel_in;
      exif.mem_zero_out       <= ~bubble & exif.ex_zero_in;
      exif.mem_regwen_out     <= ~bubble & ~squash & exif.ex_regwen_in;
      exif.mem_mem2reg_out    <= ~bubble & exif.ex_mem2reg_in;
      exif.mem_memwrite_out   <= ~bubble & ~squash & exif.ex_memwrite_in;
      exif.mem_pc2reg_out     <= ~bubble & exif.ex_pc2reg_in;
      exif.mem_halt_out       <= ~bubble & exif.ex_halt_in;
      exif.ov_trap_out        <= exif.ov_trap_out | (~bubble & squash);
    end
`ifdef EXMEM_PERF_EN
  logic [31:0] bubble_cnt, instr_cnt;
  // saturating counters, frozen outside RUN-with-update
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      bubble_cnt <= '0;
      instr_cnt  <= '0;
    end else if (load) begin
      if (bubble && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + 32'd1;
      if (!bubble && !(&instr_cnt)) instr_cnt <= instr_cnt + 32'd1;
    end
  assign exif.bubble_cnt_out = bubble_cnt;
  assign exif.instr_cnt_out = instr_cnt;
`else
  assign exif.bubble_cnt_out = '0;
  assign exif.instr_cnt_out = '0;
`endif
endmodule

// File: tb/tb_pipeline_execute.sv
// tb_pipeline_execute: randomized scoreboard bench for the EX/MEM register
module tb_pipeline_execute;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  pipeline_execute_if ifc();
  pipeline_execute dut (.CLK(CLK), .nRST(nRST), .exif(ifc));
  always #5 CLK = ~CLK;
  typedef struct packed {
    logic [31:0] instr, npc, res, rdat2;
    logic [4:0]  wsel;
    logic        zero, regwen, mem2reg, memwrite, pc2reg, halt, trap, halted;
    logic [31:0] bcnt, icnt;
  } out_t;
  out_t q[$];
  out_t m;
  int total = 0, bad = 0;
  function automatic out_t actual();
    out_t a;
    a.instr = ifc.mem_instr_out; a.npc = ifc.mem_npc_out; a.res = ifc.mem_alu_result_out;
    a.rdat2 = ifc.mem_rdat2_out; a.wsel = ifc.mem_wsel_out; a.zero = ifc.mem_zero_out;
    a.regwen = ifc.mem_regwen_out; a.mem2reg = ifc.mem_mem2reg_out; a.memwrite = ifc.mem_memwrite_out;
    a.pc2reg = ifc.mem_pc2reg_out; a.halt = ifc.mem_halt_out; a.trap = ifc.ov_trap_out;
    a.halted = ifc.halted_out; a.bcnt = ifc.bubble_cnt_out; a.icnt = ifc.instr_cnt_out;
    return a;
  endfunction
  task automatic check(input string nm, input out_t a, input out_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, a, e);
    end
  endtask
  // monitor: one registered result per clock edge
  always @(posedge CLK) begin
    #1;
    if (q.size() != 0) check("cycle", actual(), q.pop_front());
  end
  // reference: what the MEM stage should hold after this edge
  task automatic tick();
    out_t n;
    if (!m.halted && ifc.hit_check && !ifc.hit_check2) begin
      n = '0;
      n.trap = m.trap;
      n.bcnt = m.bcnt;
      n.icnt = m.icnt;
      if (ifc.stall || ifc.flush) begin
`ifdef EXMEM_PERF_EN
        if (n.bcnt != 32'hFFFF_FFFF) n.bcnt = n.bcnt + 1;
`endif
      end else begin
        n.instr = ifc.ex_instr_in; n.npc = ifc.ex_npc_in; n.res = ifc.ex_alu_result_in;
        n.rdat2 = ifc.ex_rdat2_in; n.wsel = ifc.ex_wsel_in; n.zero = ifc.ex_zero_in;
        n.mem2reg = ifc.ex_mem2reg_in; n.pc2reg = ifc.ex_pc2reg_in; n.halt = ifc.ex_halt_in;
        n.regwen = ifc.ex_regwen_in; n.memwrite = ifc.ex_memwrite_in;
        if (ifc.ex_careof_in && ifc.ex_overflow_in) begin
          n.regwen = 1'b0;
          n.memwrite = 1'b0;
          n.trap = 1'b1;
        end
        n.halted = ifc.ex_halt_in;
`ifdef EXMEM_PERF_EN
        if (n.icnt != 32'hFFFF_FFFF) n.icnt = n.icnt + 1;
`endif
      end
      m = n;
    end
    q.push_back(m);
    @(negedge CLK);
  endtask
  task automatic rnd();
    ifc.hit_check = 1'b1; ifc.hit_check2 = 1'b0; ifc.stall = 1'b0; ifc.flush = 1'b0;
    ifc.ex_instr_in = $urandom; ifc.ex_npc_in = $urandom; ifc.ex_alu_result_in = $urandom;
    ifc.ex_rdat2_in = $urandom; ifc.ex_wsel_in = 5'($urandom); ifc.ex_zero_in = 1'($urandom);
    ifc.ex_overflow_in = 1'b0; ifc.ex_regwen_in = 1'($urandom); ifc.ex_mem2reg_in = 1'($urandom);
    ifc.ex_memwrite_in = 1'($urandom); ifc.ex_pc2reg_in = 1'($urandom); ifc.ex_careof_in = 1'b0;
    ifc.ex_halt_in = 1'b0;
  endtask
  initial begin
    #600000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
  initial begin
    m = '0;
    rnd();
    #2 check("reset", actual(), '0);
    @(negedge CLK);
    nRST = 1'b1;
    // addi then asynchronous mid-cycle reset
    rnd(); ifc.ex_wsel_in = 5'd8; ifc.ex_alu_result_in = 32'h5; ifc.ex_regwen_in = 1'b1; ifc.ex_careof_in = 1'b1;
    ifc.ex_overflow_in = 1'b1;
    tick();
    #2 nRST = 1'b0;
    #1 check("async_reset", actual(), '0);
    m = '0;
    #1 nRST = 1'b1;
    // normal load then hold with no cache hit
    rnd(); ifc.ex_alu_result_in = 32'h1234; ifc.ex_wsel_in = 5'd3; ifc.ex_regwen_in = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin rnd(); ifc.hit_check = 1'b0; tick(); end
    // bubbles: flush, stall, both
    for (int i = 1; i < 4; i++) begin rnd(); ifc.flush = i[0]; ifc.stall = i[1]; tick(); end
    // overflow squash then clean instruction
    rnd(); ifc.ex_careof_in = 1'b1; ifc.ex_overflow_in = 1'b1; ifc.ex_regwen_in = 1'b1;
    ifc.ex_memwrite_in = 1'b1; ifc.ex_alu_result_in = 32'h8000_0000;
    tick();
    rnd(); ifc.ex_regwen_in = 1'b1; ifc.ex_overflow_in = 1'b1; tick();
    // memory busy then released
    rnd(); ifc.hit_check2 = 1'b1; tick();
    ifc.hit_check2 = 1'b0; tick();
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rnd();
      ifc.hit_check = ($urandom_range(0, 3) != 0);
      ifc.hit_check2 = ($urandom_range(0, 4) == 0);
      ifc.stall = ($urandom_range(0, 7) == 0);
      ifc.flush = ($urandom_range(0, 7) == 0);
      ifc.ex_careof_in = ($urandom_range(0, 3) == 0);
      ifc.ex_overflow_in = ($urandom_range(0, 3) == 0);
      tick();
    end
    // halt then attempts to disturb the frozen register
    rnd(); ifc.ex_halt_in = 1'b1; tick();
    for (int i = 0; i < 5; i++) begin rnd(); ifc.flush = 1'b1; ifc.ex_careof_in = 1'b1; ifc.ex_overflow_in = 1'b1; tick(); end
    for (int i = 0; i < 5; i++) begin rnd(); tick(); end
    @(negedge CLK);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
